// File: rtl/move_gen_sched_if.sv
// Signal bundle between move_gen_sched, its search requesters, all_moves and the result consumer.
// master is the scheduler's view; slave is the surrounding environment's view.
interface move_gen_sched_if #(
   parameter int unsigned PIECE_WIDTH        = 4,
   parameter int unsigned MAX_POSITIONS      = 64,
   parameter int unsigned NUM_REQ            = 2,
   parameter int unsigned BOARD_WIDTH        = PIECE_WIDTH * 64,
   parameter int unsigned MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS),
   parameter int unsigned REQ_ID_WIDTH       = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ*BOARD_WIDTH-1:0] req_board;
   logic [NUM_REQ-1:0]             req_white_to_move;
   logic [NUM_REQ*4-1:0]           req_castle_mask;
   logic [NUM_REQ*4-1:0]           req_en_passant_col;
   logic [NUM_REQ-1:0]             req_ready;

   logic                          gen_board_valid;
   logic [BOARD_WIDTH-1:0]        gen_board;
   logic                          gen_white_to_move;
   logic [3:0]                    gen_castle_mask;
   logic [3:0]                    gen_en_passant_col;
   logic [MAX_POSITIONS_LOG2-1:0] gen_move_index;
   logic                          gen_clear_moves;
   logic                          gen_moves_ready;
   logic [MAX_POSITIONS_LOG2-1:0] gen_move_count;
   logic [BOARD_WIDTH-1:0]        gen_board_out;
   logic                          gen_white_to_move_out;
   logic [3:0]                    gen_castle_mask_out;
   logic [3:0]                    gen_en_passant_col_out;

   logic                          out_valid;
   logic                          out_ready;
   logic [REQ_ID_WIDTH-1:0]       out_id;
   logic [MAX_POSITIONS_LOG2-1:0] out_index;
   logic                          out_last;
   logic                          out_empty;
   logic [BOARD_WIDTH-1:0]        out_board;
   logic                          out_white_to_move;
   logic [3:0]                    out_castle_mask;
   logic [3:0]                    out_en_passant_col;
   logic                          busy;

   modport master (
      input  req_valid, req_board, req_white_to_move, req_castle_mask, req_en_passant_col,
      output req_ready,
      output gen_board_valid, gen_board, gen_white_to_move, gen_castle_mask, gen_en_passant_col,
      output gen_move_index, gen_clear_moves,
      input  gen_moves_ready, gen_move_count, gen_board_out, gen_white_to_move_out,
      input  gen_castle_mask_out, gen_en_passant_col_out,
      output out_valid, out_id, out_index, out_last, out_empty, out_board,
      output out_white_to_move, out_castle_mask, out_en_passant_col,
      input  out_ready,
      output busy
   );

   modport slave (
      output req_valid, req_board, req_white_to_move, req_castle_mask, req_en_passant_col,
      input  req_ready,
      input  gen_board_valid, gen_board, gen_white_to_move, gen_castle_mask, gen_en_passant_col,
      input  gen_move_index, gen_clear_moves,
      output gen_moves_ready, gen_move_count, gen_board_out, gen_white_to_move_out,
      output gen_castle_mask_out, gen_en_passant_col_out,
      input  out_valid, out_id, out_index, out_last, out_empty, out_board,
      input  out_white_to_move, out_castle_mask, out_en_passant_col,
      output out_ready,
      input  busy
   );
endinterface

// File: rtl/move_gen_sched.sv
// Round-robin scheduler sharing one all_moves generator among NUM_REQ searchers:
// load a root position, walk the generated-move RAM by index and stream each result out.
module move_gen_sched #(
   parameter int unsigned PIECE_WIDTH        = 4,
   parameter int unsigned MAX_POSITIONS      = 64,
   parameter int unsigned NUM_REQ            = 2,
   parameter int unsigned BOARD_WIDTH        = PIECE_WIDTH * 64,
   parameter int unsigned MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS),
   parameter int unsigned REQ_ID_WIDTH       = $clog2(NUM_REQ)
) (
   input logic              clk,
   input logic              reset,
   move_gen_sched_if.master bus
);
   localparam int unsigned MPL = MAX_POSITIONS_LOG2;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_GO, S_WAIT, S_FETCH, S_CAPTURE, S_PRESENT, S_CLEAR, S_SETTLE
   } state_e;

   state_e                  state_q, state_d;
   logic [REQ_ID_WIDTH-1:0] rr_q, rr_d, gid_q, gid_d;
   logic [MPL-1:0]          k_q, k_d, move_index_q, move_index_d;
   logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
   logic [BOARD_WIDTH-1:0]  gen_board_q, gen_board_d;
   logic                    gen_wtm_q, gen_wtm_d;
   logic [3:0]              gen_castle_q, gen_castle_d, gen_ep_q, gen_ep_d;
   logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic                    out_empty_q, out_empty_d, out_wtm_q, out_wtm_d;
   logic [REQ_ID_WIDTH-1:0] out_id_q, out_id_d;
   logic [MPL-1:0]          out_index_q, out_index_d;
   logic [BOARD_WIDTH-1:0]  out_board_q, out_board_d;
   logic [3:0]              out_castle_q, out_castle_d, out_ep_q, out_ep_d;

   logic                    grant_found;
   logic [REQ_ID_WIDTH-1:0] grant_id;

   // Search upward from rr+1 so the previous winner is considered last.
   always_comb begin
      int unsigned idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_id    = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx = (32'(rr_q) + i) % NUM_REQ;
         if (!grant_found && bus.req_valid[idx]) begin
            grant_found = 1'b1;
            grant_id    = REQ_ID_WIDTH'(idx);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      gid_d        = gid_q;
      k_d          = k_q;
      move_index_d = move_index_q;
      req_ready_d  = '0;
      gen_board_d  = gen_board_q;
      gen_wtm_d    = gen_wtm_q;
      gen_castle_d = gen_castle_q;
      gen_ep_d     = gen_ep_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      out_empty_d  = out_empty_q;
      out_id_d     = out_id_q;
      out_index_d  = out_index_q;
      out_board_d  = out_board_q;
      out_wtm_d    = out_wtm_q;
      out_castle_d = out_castle_q;
      out_ep_d     = out_ep_q;
      case (state_q)
         S_IDLE: if (grant_found) begin
            gen_board_d           = bus.req_board[grant_id*BOARD_WIDTH +: BOARD_WIDTH];
            gen_wtm_d             = bus.req_white_to_move[grant_id];
            gen_castle_d          = bus.req_castle_mask[grant_id*4 +: 4];
            gen_ep_d              = bus.req_en_passant_col[grant_id*4 +: 4];
            gid_d                 = grant_id;
            rr_d                  = grant_id;
            req_ready_d[grant_id] = 1'b1;
            state_d               = S_LOAD;
         end
         S_LOAD: state_d = S_GO;
         S_GO:   state_d = S_WAIT;
         S_WAIT: if (bus.gen_moves_ready) begin
            k_d = '0;
            if (bus.gen_move_count == '0) begin
               out_empty_d = 1'b1;
               out_last_d  = 1'b1;
               out_index_d = '0;
               out_id_d    = gid_q;
               out_valid_d = 1'b1;
               state_d     = S_PRESENT;
            end else begin
               move_index_d = '0;
               state_d      = S_FETCH;
            end
         end
         // all_moves RAM has one cycle of read latency: index in FETCH, data in CAPTURE.
         S_FETCH: state_d = S_CAPTURE;
         S_CAPTURE: begin
            out_board_d  = bus.gen_board_out;
            out_wtm_d    = bus.gen_white_to_move_out;
            out_castle_d = bus.gen_castle_mask_out;
            out_ep_d     = bus.gen_en_passant_col_out;
            out_index_d  = k_q;
            out_id_d     = gid_q;
            out_empty_d  = 1'b0;
            out_last_d   = (k_q == bus.gen_move_count - 1'b1);
            out_valid_d  = 1'b1;
            state_d      = S_PRESENT;
         end
         S_PRESENT: if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
               state_d = S_CLEAR;
            end else begin
               k_d          = k_q + 1'b1;
               move_index_d = k_q + 1'b1;
               state_d      = S_FETCH;
            end
         end
         S_CLEAR:  state_d = S_SETTLE;
         S_SETTLE: if (!bus.gen_moves_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         rr_q         <= REQ_ID_WIDTH'(NUM_REQ - 1);
         gid_q        <= '0;
         k_q          <= '0;
         move_index_q <= '0;
         req_ready_q  <= '0;
         gen_board_q  <= '0;
         gen_wtm_q    <= 1'b0;
         gen_castle_q <= '0;
         gen_ep_q     <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_empty_q  <= 1'b0;
         out_id_q     <= '0;
         out_index_q  <= '0;
         out_board_q  <= '0;
         out_wtm_q    <= 1'b0;
         out_castle_q <= '0;
         out_ep_q     <= '0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         gid_q        <= gid_d;
         k_q          <= k_d;
         move_index_q <= move_index_d;
         req_ready_q  <= req_ready_d;
         gen_board_q  <= gen_board_d;
         gen_wtm_q    <= gen_wtm_d;
         gen_castle_q <= gen_castle_d;
         gen_ep_q     <= gen_ep_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_empty_q  <= out_empty_d;
         out_id_q     <= out_id_d;
         out_index_q  <= out_index_d;
         out_board_q  <= out_board_d;
         out_wtm_q    <= out_wtm_d;
         out_castle_q <= out_castle_d;
         out_ep_q     <= out_ep_d;
      end
   end

   assign bus.req_ready          = req_ready_q;
   assign bus.gen_board_valid    = (state_q == S_GO);
   assign bus.gen_clear_moves    = (state_q == S_CLEAR);
   assign bus.gen_board          = gen_board_q;
   assign bus.gen_white_to_move  = gen_wtm_q;
   assign bus.gen_castle_mask    = gen_castle_q;
   assign bus.gen_en_passant_col = gen_ep_q;
   assign bus.gen_move_index     = move_index_q;
   assign bus.out_valid          = out_valid_q;
   assign bus.out_id             = out_id_q;
   assign bus.out_index          = out_index_q;
   assign bus.out_last           = out_last_q;
   assign bus.out_empty          = out_empty_q;
   assign bus.out_board          = out_board_q;
   assign bus.out_white_to_move  = out_wtm_q;
   assign bus.out_castle_mask    = out_castle_q;
   assign bus.out_en_passant_col = out_ep_q;
   assign bus.busy               = (state_q != S_IDLE);
endmodule

// File: tb/tb_move_gen_sched.sv
// Directed bench for move_gen_sched with a behavioural all_moves stand-in whose move
// count is the low index bits of the loaded board and whose result i is board ^ (i << 8).
module tb_move_gen_sched;
   localparam int unsigned PW  = 4;
   localparam int unsigned MP  = 64;
   localparam int unsigned NR  = 2;
   localparam int unsigned BW  = PW * 64;
   localparam int unsigned MPL = $clog2(MP);

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   int   clr_pulses = 0;

   always #5 clk = ~clk;

   move_gen_sched_if #(.PIECE_WIDTH(PW), .MAX_POSITIONS(MP), .NUM_REQ(NR)) bus ();

   move_gen_sched #(.PIECE_WIDTH(PW), .MAX_POSITIONS(MP), .NUM_REQ(NR)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // all_moves stand-in: moves_ready 3 cycles after board_valid, drops 2 cycles after clear.
   logic [BW-1:0] m_board;
   logic          m_wtm;
   logic [3:0]    m_cas, m_ep;
   int            m_dly, m_clr_dly;

   always @(posedge clk) begin
      if (!reset) begin
         bus.gen_moves_ready        <= 1'b0;
         bus.gen_move_count         <= '0;
         bus.gen_board_out          <= '0;
         bus.gen_white_to_move_out  <= 1'b0;
         bus.gen_castle_mask_out    <= '0;
         bus.gen_en_passant_col_out <= '0;
         m_board <= '0; m_wtm <= 1'b0; m_cas <= '0; m_ep <= '0;
         m_dly <= 0; m_clr_dly <= 0;
      end else begin
         if (bus.gen_board_valid) begin
            m_board <= bus.gen_board;
            m_wtm   <= bus.gen_white_to_move;
            m_cas   <= bus.gen_castle_mask;
            m_ep    <= bus.gen_en_passant_col;
            m_dly   <= 3;
         end else if (m_dly == 1) begin
            bus.gen_moves_ready <= 1'b1;
            bus.gen_move_count  <= m_board[MPL-1:0];
            m_dly <= 0;
         end else if (m_dly > 1) begin
            m_dly <= m_dly - 1;
         end
         if (bus.gen_clear_moves) begin
            m_clr_dly <= 2;
         end else if (m_clr_dly == 1) begin
            bus.gen_moves_ready <= 1'b0;
            bus.gen_move_count  <= '0;
            m_clr_dly <= 0;
         end else if (m_clr_dly > 1) begin
            m_clr_dly <= m_clr_dly - 1;
         end
         bus.gen_board_out          <= m_board ^ (BW'(bus.gen_move_index) << 8);
         bus.gen_white_to_move_out  <= ~m_wtm;
         bus.gen_castle_mask_out    <= m_cas ^ 4'(bus.gen_move_index);
         bus.gen_en_passant_col_out <= m_ep;
      end
   end

   always @(negedge clk) if (reset && bus.gen_clear_moves) clr_pulses++;

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] make_board(input int id, input int n);
      logic [BW-1:0] b;
      b = {(BW/32){32'h5A3C_96E1}};
      b[BW-1 -: 8] = 8'(id + 1);
      b[7:0] = 8'(n);
      return b;
   endfunction

   task automatic request(input int id, input int n, input logic wtm, input logic [3:0] cas,
                          input logic [3:0] ep, output logic [BW-1:0] brd);
      brd = make_board(id, n);
      bus.req_board[id*BW +: BW]       = brd;
      bus.req_white_to_move[id]        = wtm;
      bus.req_castle_mask[id*4 +: 4]   = cas;
      bus.req_en_passant_col[id*4 +: 4] = ep;
      bus.req_valid[id]                = 1'b1;
   endtask

   task automatic accept(input int id, input logic [BW-1:0] brd, input logic drop);
      int t;
      t = 0;
      while (bus.req_ready == '0 && t < 20) begin @(negedge clk); t++; end
      chk("req_ready", bus.req_ready, NR'(1) << id);
      chk("gen_board_load", bus.gen_board, brd);
      chk("board_valid_load", bus.gen_board_valid, 0);
      if (drop) bus.req_valid[id] = 1'b0;
      @(negedge clk);
      chk("board_valid_go", bus.gen_board_valid, 1);
      chk("req_ready_pulse", bus.req_ready, 0);
      @(negedge clk);
      chk("board_valid_wait", bus.gen_board_valid, 0);
   endtask

   task automatic drain(input int id, input int n, input logic [BW-1:0] brd, input logic wtm,
                        input logic [3:0] cas, input logic [3:0] ep, input int stall,
                        input int stop_after);
      int            t, beats;
      logic          exp_w;
      logic [BW-1:0] snap;
      beats = (n == 0) ? 1 : n;
      exp_w = ~wtm;
      for (int b = 0; b < beats; b++) begin
         t = 0;
         while (!bus.out_valid && t < 40) begin @(negedge clk); t++; end
         chk("out_valid", bus.out_valid, 1);
         chk("valid_vs_clear", bus.gen_clear_moves, 0);
         chk("out_id", bus.out_id, id);
         chk("out_index", bus.out_index, b);
         chk("out_last", bus.out_last, b == beats - 1);
         chk("out_empty", bus.out_empty, n == 0);
         if (n != 0) begin
            chk("out_board", bus.out_board, brd ^ (BW'(b) << 8));
            chk("out_wtm", bus.out_white_to_move, exp_w);
            chk("out_castle", bus.out_castle_mask, cas ^ 4'(b));
            chk("out_ep", bus.out_en_passant_col, ep);
            chk("gen_move_index", bus.gen_move_index, b);
         end
         snap = bus.out_board;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_board", bus.out_board, snap);
            chk("stall_index", bus.out_index, b);
            chk("stall_move_index", bus.gen_move_index, b);
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
         if (b + 1 == stop_after) return;
      end
   endtask

   task automatic finish_pos(input int c0);
      int t;
      t = 0;
      while (bus.busy && t < 20) begin @(negedge clk); t++; end
      chk("busy_idle", bus.busy, 0);
      chk("clear_once", clr_pulses - c0, 1);
   endtask

   initial begin
      logic [BW-1:0] b0, b1;
      int            c0;
      bus.req_valid = '0; bus.req_board = '0; bus.req_white_to_move = '0;
      bus.req_castle_mask = '0; bus.req_en_passant_col = '0; bus.out_ready = 1'b0;

      // Reset held with both requesters pending.
      request(0, 20, 1'b1, 4'hf, 4'h8, b0);
      request(1, 3, 1'b0, 4'h3, 4'h2, b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_req_ready", bus.req_ready, 0);
      end
      chk("rst_busy", bus.busy, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_board_valid", bus.gen_board_valid, 0);
      chk("rst_clear", bus.gen_clear_moves, 0);
      chk("rst_move_index", bus.gen_move_index, 0);
      chk("rst_gen_board", bus.gen_board, 0);
      chk("rst_out_board", bus.out_board, 0);
      reset = 1'b1;

      // Requester 0 first, 20 beats.
      c0 = clr_pulses;
      accept(0, b0, 1'b1);
      bus.req_valid = '0;
      drain(0, 20, b0, 1'b1, 4'hf, 4'h8, 0, 0);
      finish_pos(c0);

      // Back-pressure: one cycle ready, three cycles stalled.
      request(1, 4, 1'b0, 4'h5, 4'h3, b1);
      c0 = clr_pulses;
      accept(1, b1, 1'b1);
      drain(1, 4, b1, 1'b0, 4'h5, 4'h3, 3, 0);
      finish_pos(c0);

      // Round-robin with both requesters held valid.
      request(0, 2, 1'b1, 4'ha, 4'h1, b0);
      request(1, 1, 1'b0, 4'h6, 4'h4, b1);
      for (int i = 0; i < 4; i++) begin
         c0 = clr_pulses;
         if (i % 2 == 0) begin
            accept(0, b0, 1'b0);
            drain(0, 2, b0, 1'b1, 4'ha, 4'h1, 0, 0);
         end else begin
            accept(1, b1, 1'b0);
            drain(1, 1, b1, 1'b0, 4'h6, 4'h4, 0, 0);
         end
         finish_pos(c0);
      end
      bus.req_valid = '0;

      // Zero-move position.
      request(0, 0, 1'b1, 4'h0, 4'h8, b0);
      c0 = clr_pulses;
      accept(0, b0, 1'b1);
      drain(0, 0, b0, 1'b1, 4'h0, 4'h8, 0, 0);
      finish_pos(c0);

      // Reset after the 5th beat of a 10-move position.
      request(1, 10, 1'b0, 4'hc, 4'h7, b1);
      accept(1, b1, 1'b1);
      drain(1, 10, b1, 1'b0, 4'hc, 4'h7, 0, 5);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_move_index", bus.gen_move_index, 0);
      chk("mid_rst_out_index", bus.out_index, 0);
      chk("mid_rst_out_board", bus.out_board, 0);
      chk("mid_rst_gen_board", bus.gen_board, 0);
      reset = 1'b1;
      request(0, 2, 1'b1, 4'h9, 4'h5, b0);
      c0 = clr_pulses;
      accept(0, b0, 1'b1);
      drain(0, 2, b0, 1'b1, 4'h9, 4'h5, 0, 0);
      finish_pos(c0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/move_gen_sched.md
Name: move_gen_sched

Overview:
- Round-robin scheduler that shares one all_moves move generator between NUM_REQ search requesters.
- Accepts a root position from one requester and loads it into all_moves, then waits for moves_ready.
- Reads every generated position out of the all_moves RAM by move_index and streams it to the winning requester over a valid/ready channel.
- Finally pulses clear_moves and returns all_moves to idle before the next arbitration. It sits between the search engines and all_moves.

Parameters:
- PIECE_WIDTH, `PIECE_BITS: bits per square.
- BOARD_WIDTH, PIECE_WIDTH*64: packed board width.
- MAX_POSITIONS, `MAX_POSITIONS: all_moves RAM depth.
- MAX_POSITIONS_LOG2, $clog2(MAX_POSITIONS): index/count width (MPL).
- NUM_REQ, 2: number of requesters, 2..8.
- REQ_ID_WIDTH, $clog2(NUM_REQ): requester id width.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-low reset.
- req_valid, in, NUM_REQ: per-requester position pending.
- req_board, in, NUM_REQ*BOARD_WIDTH: requester i board in slice i.
- req_white_to_move, in, NUM_REQ: side to move.
- req_castle_mask, in, NUM_REQ*4: castle mask.
- req_en_passant_col, in, NUM_REQ*4: en passant column.
- req_ready, out, NUM_REQ: one-hot, one-cycle accept pulse.
- gen_board_valid, out, 1: to all_moves board_valid.
- gen_board, out, BOARD_WIDTH: to all_moves board_in.
- gen_white_to_move, out, 1: to all_moves white_to_move_in.
- gen_castle_mask, out, 4: to all_moves castle_mask_in.
- gen_en_passant_col, out, 4: to all_moves en_passant_col_in.
- gen_move_index, out, MPL: to all_moves move_index.
- gen_clear_moves, out, 1: to all_moves clear_moves.
- gen_moves_ready, in, 1: from all_moves.
- gen_move_count, in, MPL: from all_moves.
- gen_board_out, in, BOARD_WIDTH: from all_moves.
- gen_white_to_move_out, in, 1: from all_moves.
- gen_castle_mask_out, in, 4: from all_moves.
- gen_en_passant_col_out, in, 4: from all_moves.
- out_valid, out, 1: result beat valid.
- out_ready, in, 1: consumer accepts beat.
- out_id, out, REQ_ID_WIDTH: requester that owns the beat.
- out_index, out, MPL: move number within the position.
- out_last, out, 1: final beat of the position.
- out_empty, out, 1: position produced zero moves; out_board etc. are don't-care.
- out_board, out, BOARD_WIDTH: result position.
- out_white_to_move, out, 1: result side to move.
- out_castle_mask, out, 4: result castle mask.
- out_en_passant_col, out, 4: result en passant column.
- busy, out, 1: high in every state except IDLE.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE. Every output is 0, including req_ready, gen_*, out_*, busy and gen_move_index.
  - The rr pointer is set to NUM_REQ-1, so requester 0 wins first.
  - The integration drives all_moves reset as ~reset. A reset mid-operation abandons the current position with no out_last.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from rr+1 modulo NUM_REQ.
  - On grant: latch that requester's board, side to move, castle mask and en passant column into the gen_* registers; record gid; set rr<=gid; pulse req_ready[gid] for one cycle; go to LOAD.
  - The requester must hold its inputs until it sees req_ready.
- LOAD: gen_* inputs are stable and gen_board_valid=0. This gives all_moves one cycle to capture board_in. Go to GO.
- GO: gen_board_valid=1 for exactly this cycle. Go to WAIT.
- WAIT: hold gen_* stable. When gen_moves_ready=1, set k<=0.
  - If gen_move_count==0: load out_empty=1, out_last=1, out_index=0, out_id=gid, out_valid<=1; go to PRESENT.
  - Otherwise drive gen_move_index<=0 and go to FETCH.
- FETCH: gen_move_index holds k for this cycle. The all_moves RAM read has 1 cycle of latency. Go to CAPTURE.
- CAPTURE:
  - Register gen_board_out, gen_white_to_move_out, gen_castle_mask_out and gen_en_passant_col_out into out_*.
  - Set out_index<=k, out_id<=gid, out_empty<=0, out_last<=(k==gen_move_count-1), out_valid<=1. Go to PRESENT.
- PRESENT:
  - out_* are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid<=0. If out_last, go to CLEAR. Otherwise k<=k+1, gen_move_index<=k+1, go to FETCH.
  - Minimum cost is 3 cycles per move.
- CLEAR: gen_clear_moves=1 for one cycle. Go to SETTLE.
- SETTLE: go to IDLE once gen_moves_ready==0. This guarantees all_moves is back in its idle state before the next GO.
- gen_move_count is sampled each use. It is constant from moves_ready until clear. k never exceeds count-1.
- req_valid changes during service are ignored. Arbitration happens only in IDLE, so at most one position is in flight.
- If the same requester re-asserts, it is granted again only when no other requester is valid.
- out_valid never rises in the same cycle as gen_clear_moves.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req_valid=2'b11 -> all outputs 0, no req_ready pulse. Release reset -> req_ready=2'b01 first, then LOAD, then gen_board_valid high for exactly 1 cycle.
- Initial position for requester 0, white to move, castle 4'hf, en passant invalid -> 20 beats, out_index 0..19, out_id=0, out_last only on index 19, every beat has out_white_to_move=0. gen_clear_moves pulses once after the last handshake.
- Back-pressure: out_ready toggled as 1 cycle high, 3 cycles low -> out_* stable while stalled, no beat dropped or duplicated, and gen_move_index advances only after a handshake.
- Round-robin: req_valid=2'b11 held -> grants alternate 0,1,0,1, and each position's beats carry the matching out_id with no interleaving.
- Zero-move board (only a king of the side to move that cannot move, or no pieces of that side) -> single beat with out_empty=1, out_last=1, out_index=0, then clear, then IDLE.
- Reset mid-stream after the 5th beat -> outputs 0 the next cycle. A new request after release completes normally starting at out_index 0.
